alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mult_iter.sv | 49 ++++
 rtl/alu_seq.sv | 126 ++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes (as produced by ALU_Ctrl) and the alu_seq state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mult_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles, low WIDTH product bits.
module alu_mult_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  // done_o/product_o describe the final step, so the caller can latch on the same edge.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(1));
  assign product_o = acc_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready request and result handshakes.
// Define ALU_SEQ_MULT_EN to add the iterative multiply (code 1000); otherwise 1000 is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             illegal_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [1:0]       state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q, res_d, sum_d, diff_d;
  logic             zero_q, ovf_q, illegal_q, valid_q;
  logic             ovf_d, illegal_d, is_mul_d, accept;

  assign ready_o   = (state_q == IDLE) || (state_q == DONE && ready_i);
  assign accept    = valid_i && ready_o;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign ovf_o     = ovf_q;
  assign illegal_o = illegal_q;
  assign valid_o   = valid_q;
  assign state_o   = state_q;

  assign sum_d  = src1_i + src2_i;
  assign diff_d = src1_i - src2_i;

  always_comb begin
    res_d     = '0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    is_mul_d  = 1'b0;
    case (ctrl_i)
      ALU_AND: res_d = src1_i & src2_i;
      ALU_OR:  res_d = src1_i | src2_i;
      ALU_ADD: begin
        res_d = sum_d;
        ovf_d = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum_d[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = diff_d;
        ovf_d = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff_d[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_NOR: res_d = ~(src1_i | src2_i);
`ifdef ALU_SEQ_MULT_EN
      ALU_MUL: is_mul_d = 1'b1;
`endif
      default: illegal_d = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULT_EN
  logic             mult_busy, mult_done;
  logic [WIDTH-1:0] mult_product;

  alu_mult_iter #(.WIDTH(WIDTH)) u_mult (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (accept && is_mul_d),
    .a_i       (src1_i),
    .b_i       (src2_i),
    .busy_o    (mult_busy),
    .done_o    (mult_done),
    .product_o (mult_product)
  );
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (accept) begin
      if (is_mul_d) begin
        state_q   <= BUSY;
        result_q  <= '0;
        zero_q    <= 1'b0;
        ovf_q     <= 1'b0;
        illegal_q <= 1'b0;
        valid_q   <= 1'b0;
      end else begin
        state_q   <= DONE;
        result_q  <= res_d;
        zero_q    <= (res_d == '0);
        ovf_q     <= ovf_d;
        illegal_q <= illegal_d;
        valid_q   <= 1'b1;
      end
    end
`ifdef ALU_SEQ_MULT_EN
    else if (state_q == BUSY && mult_busy && mult_done) begin
      state_q   <= DONE;
      result_q  <= mult_product;
      zero_q    <= (mult_product == '0);
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b1;
    end
`endif
    else if (state_q == DONE && ready_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, back-pressure, back-to-back, resets, random ops.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   ctrl_i;
  logic [W-1:0] src1_i, src2_i;
  logic         valid_i, ready_i;
  logic         ready_o, zero_o, ovf_o, illegal_o, valid_o;
  logic [W-1:0] result_o;
  logic [1:0]   state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ctrl_i    (ctrl_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o),
    .illegal_o (illegal_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .state_o   (state_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model from the operation definitions, using 64-bit signed arithmetic.
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic o, output logic ill,
                                output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; o = 1'b0; ill = 1'b0; lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
`ifdef ALU_SEQ_MULT_EN
      4'b1000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; lat = W; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Driver: issue one op from IDLE, measure latency, check outputs, hold back-pressure, then drain.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] r;
    logic o, ill;
    int lat, cyc;
    bit got;
    model(c, a, b, r, o, ill, lat);
    @(negedge clk_i);
    check({tag, "_rdy"}, W'(ready_o), 1);
    ctrl_i = c; src1_i = a; src2_i = b; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (valid_o === 1'b1) got = 1;
    end
    check({tag, "_lat"}, W'(cyc), W'(lat));
    check({tag, "_res"}, result_o, r);
    check({tag, "_zero"}, W'(zero_o), W'(r == '0));
    check({tag, "_ovf"}, W'(ovf_o), W'(o));
    check({tag, "_ill"}, W'(illegal_o), W'(ill));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check({tag, "_hold_res"}, result_o, r);
      check({tag, "_hold_vld"}, W'(valid_o), 1);
      check({tag, "_hold_rdy"}, W'(ready_o), 0);
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1 ready_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_drained"}, W'(valid_o), 0);
    check({tag, "_idle_rdy"}, W'(ready_o), 1);
  endtask

  // Start an op, wait `wait_cyc` cycles after accept, then pulse reset mid-operation.
  task automatic reset_mid(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int wait_cyc, input string tag);
    @(negedge clk_i);
    ctrl_i = c; src1_i = a; src2_i = b; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    repeat (wait_cyc) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check({tag, "_res"}, result_o, 0);
    check({tag, "_vld"}, W'(valid_o), 0);
    check({tag, "_zero"}, W'(zero_o), 0);
    check({tag, "_ovf"}, W'(ovf_o), 0);
    check({tag, "_ill"}, W'(illegal_o), 0);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check({tag, "_rdy"}, W'(ready_o), 1);
    // The abandoned operation must never produce a result.
    got_none: begin
      bit seen;
      seen = 0;
      repeat (W + 8) begin
        @(negedge clk_i);
        if (valid_o !== 1'b0) seen = 1;
      end
      check({tag, "_no_out"}, W'(seen), 0);
    end
  endtask

  logic [3:0]   codes[8];
  logic [W-1:0] corners[5];

  function automatic logic [W-1:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [3:0]   c;
    logic [W-1:0] a, b, r;
    logic         o, ill;
    int           lat;

    codes   = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0011};
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    // Reset
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    ctrl_i = '0; src1_i = '0; src2_i = '0;
    #1;
    check("rst_res", result_o, 0);
    check("rst_vld", W'(valid_o), 0);
    check("rst_zero", W'(zero_o), 0);
    check("rst_ovf", W'(ovf_o), 0);
    check("rst_ill", W'(illegal_o), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_rdy", W'(ready_o), 1);

    // Directed corner cases
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
    check("add_ovf_const", result_o, 32'h8000_0000);
    run_op(4'b0110, 32'd5, 32'd5, 0, "sub_zero");
    run_op(4'b0110, 32'h8000_0000, 32'h1, 0, "sub_ovf");
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 0, "slt_neg");
    run_op(4'b0111, 32'h1, 32'hFFFF_FFFF, 0, "slt_pos");
    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, "and_bp");
    run_op(4'b1100, 32'h1234_5678, 32'h0F0F_0000, 0, "nor");
    run_op(4'b0011, 32'h1, 32'h2, 0, "illegal");
    run_op(4'b1000, 32'd1234, 32'd5678, 0, "mul");
`ifdef ALU_SEQ_MULT_EN
    check("mul_const", result_o, 32'd7006652);
`endif

    // Back-to-back: valid_i and ready_i held high, one result per cycle in order
    @(negedge clk_i);
    ready_i = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        check("b2b_vld", W'(valid_o), 1);
        check("b2b_res", result_o, exp_q.pop_front());
        check("b2b_rdy", W'(ready_o), 1);
      end
      if (i < 4) begin
        c = codes[$urandom_range(0, 5)];
        a = rand_operand();
        b = rand_operand();
        model(c, a, b, r, o, ill, lat);
        exp_q.push_back(r);
        ctrl_i = c; src1_i = a; src2_i = b; valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk_i);
    end
    check("b2b_end_vld", W'(valid_o), 0);
    check("b2b_q_empty", W'(exp_q.size()), 0);
    ready_i = 1'b0;

    // Reset while holding a result in DONE, and mid-multiply when enabled
    reset_mid(4'b0010, 32'h10, 32'h20, 1, "rst_done");
`ifdef ALU_SEQ_MULT_EN
    reset_mid(4'b1000, 32'd1234, 32'd5678, 10, "rst_mul");
`endif

    // Randomized operations
    for (int k = 0; k < 30; k++) begin
      c = codes[$urandom_range(0, 7)];
      if (c == 4'b0011) c = 4'($urandom_range(0, 15));
      run_op(c, rand_operand(), rand_operand(), $urandom_range(0, 2), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
